// File: rtl/noc_msg_splitter_if.sv
// Header flit layout and the grouped handshake bundle shared by the splitter and its neighbours.
// The header struct must stay exactly one NoC flit wide.
package noc_msg_splitter_pkg;

    typedef struct packed {
        logic [463:0] payload;
        logic [7:0]   msg_type;
        logic [15:0]  src_id;
        logic [15:0]  dst_id;
        logic [7:0]   msg_len;
    } noc_hdr_flit;

endpackage

interface noc_msg_splitter_if #(
    parameter int NOC_DATA_W = 512
);
    logic                              noc_in_val;
    logic [NOC_DATA_W-1:0]             noc_in_data;
    logic                              noc_in_rdy;
    logic                              hdr_val;
    noc_msg_splitter_pkg::noc_hdr_flit hdr_data;
    logic                              hdr_rdy;
    logic                              data_val;
    logic [NOC_DATA_W-1:0]             data_data;
    logic                              data_last;
    logic                              data_rdy;

    // master is the splitter itself; slave is the surrounding fabric
    modport master (
        input  noc_in_val, noc_in_data, hdr_rdy, data_rdy,
        output noc_in_rdy, hdr_val, hdr_data, data_val, data_data, data_last
    );

    modport slave (
        output noc_in_val, noc_in_data, hdr_rdy, data_rdy,
        input  noc_in_rdy, hdr_val, hdr_data, data_val, data_data, data_last
    );
endinterface

// File: rtl/noc_msg_splitter.sv
// Splits a NoC message into a registered header and a zero-latency body stream,
// counting completed messages.
module noc_msg_splitter
    import noc_msg_splitter_pkg::*;
#(
    parameter int NOC_DATA_W = 512,
    parameter int CNT_W      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    noc_msg_splitter_if.master   bus,
    output logic [CNT_W-1:0]     msg_cnt
);

    typedef enum logic [1:0] {
        HDR_IN,
        HDR_OUT,
        BODY
    } state_t;

    state_t           state_reg, state_next;
    logic [7:0]       remaining_reg, remaining_next;
    logic [CNT_W-1:0] msg_cnt_reg, msg_cnt_next;
    noc_hdr_flit      hdr_data_reg;
    noc_hdr_flit      hdr_in;
    logic             hdr_capture;
    logic             noc_in_rdy_int;
    logic             hdr_val_int;
    logic             data_val_int;
    logic             data_last_int;

    assign hdr_in = bus.noc_in_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= HDR_IN;
            remaining_reg <= '0;
            hdr_data_reg  <= '0;
            msg_cnt_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            remaining_reg <= remaining_next;
            msg_cnt_reg   <= msg_cnt_next;
            if (hdr_capture) begin
                hdr_data_reg <= hdr_in;
            end
        end
    end

    // Every output is forced idle while rst is high so no handshake can land during reset.
    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        msg_cnt_next   = msg_cnt_reg;
        hdr_capture    = 1'b0;
        noc_in_rdy_int = 1'b0;
        hdr_val_int    = 1'b0;
        data_val_int   = 1'b0;
        data_last_int  = 1'b0;
        if (!rst) begin
            case (state_reg)
                HDR_IN: begin
                    noc_in_rdy_int = 1'b1;
                    if (bus.noc_in_val) begin
                        hdr_capture    = 1'b1;
                        remaining_next = hdr_in.msg_len;
                        state_next     = HDR_OUT;
                    end
                end
                HDR_OUT: begin
                    hdr_val_int = 1'b1;
                    if (bus.hdr_rdy) begin
                        if (remaining_reg == 8'd0) begin
                            state_next   = HDR_IN;
                            msg_cnt_next = msg_cnt_reg + CNT_W'(1);
                        end else begin
                            state_next = BODY;
                        end
                    end
                end
                BODY: begin
                    data_val_int   = bus.noc_in_val;
                    noc_in_rdy_int = bus.data_rdy;
                    data_last_int  = (remaining_reg == 8'd1);
                    if (bus.noc_in_val && bus.data_rdy) begin
                        remaining_next = remaining_reg - 8'd1;
                        if (remaining_reg == 8'd1) begin
                            state_next   = HDR_IN;
                            msg_cnt_next = msg_cnt_reg + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_next = HDR_IN;
                end
            endcase
        end
    end

    assign bus.noc_in_rdy = noc_in_rdy_int;
    assign bus.hdr_val    = hdr_val_int;
    assign bus.hdr_data   = hdr_data_reg;
    assign bus.data_val   = data_val_int;
    assign bus.data_data  = bus.noc_in_data;
    assign bus.data_last  = data_last_int;
    assign msg_cnt        = msg_cnt_reg;

endmodule

// File: doc/noc_msg_splitter.md
NOC_MSG_SPLITTER -- requirements
Module: noc_msg_splitter

Interface
REQ-001 SHALL have parameter NOC_DATA_W, default 512, NoC flit width; SHALL equal $bits(noc_hdr_flit).
REQ-002 SHALL have parameter CNT_W, default 32, width of the completed-message counter.
REQ-003 SHALL have ports clk (input, 1, sole clock) and rst (input, 1, synchronous active-high reset); one clock, reset synchronous and active-high.
REQ-004 SHALL have port noc_in_val (input, 1): upstream flit valid.
REQ-005 SHALL have port noc_in_data (input, NOC_DATA_W): upstream flit.
REQ-006 SHALL have port noc_in_rdy (output, 1): splitter accepts flit.
REQ-007 SHALL have port hdr_val (output, 1): captured header valid.
REQ-008 SHALL have port hdr_data (output, noc_hdr_flit): captured header fields.
REQ-009 SHALL have port hdr_rdy (input, 1): header consumer ready.
REQ-010 SHALL have port data_val (output, 1): body flit valid.
REQ-011 SHALL have port data_data (output, NOC_DATA_W): body flit.
REQ-012 SHALL have port data_last (output, 1): final body flit of message.
REQ-013 SHALL have port data_rdy (input, 1): body consumer ready.
REQ-014 SHALL have port msg_cnt (output, CNT_W): count of completed messages.

Function
REQ-015 All handshakes SHALL be val/rdy; a transfer occurs on a rising clk edge with val and rdy both high; val SHALL NOT depend on rdy.
REQ-016 FSM SHALL have states HDR_IN, HDR_OUT, BODY.
REQ-017 HDR_IN: noc_in_rdy=1, hdr_val=0, data_val=0; on noc_in handshake, noc_in_data SHALL be registered into hdr_data, msg_len into an 8-bit remaining counter, next state HDR_OUT.
REQ-018 HDR_OUT: hdr_val=1, noc_in_rdy=0, data_val=0; hdr_data SHALL remain stable until hdr handshake.
REQ-019 On hdr handshake: msg_len==0 -> HDR_IN and msg_cnt increments; msg_len!=0 -> BODY.
REQ-020 No body flit SHALL pass before its header is accepted; no header of message N+1 SHALL be captured before message N body completes.
REQ-021 BODY: data_val=noc_in_val, data_data=noc_in_data, noc_in_rdy=data_rdy, all combinational (zero-cycle latency); hdr_val=0.
REQ-022 BODY: data_last SHALL be 1 iff remaining==1; data_last=0 outside BODY.
REQ-023 On each body handshake remaining SHALL decrement by 1; handshake with remaining==1 -> HDR_IN and msg_cnt increments the same edge.
REQ-024 Header latency: header flit accepted at edge N -> hdr_val=1 from cycle N+1.
REQ-025 Throughput: back-to-back zero-length messages SHALL sustain one message per 2 cycles with hdr_rdy held high; body flits SHALL sustain one per cycle.
REQ-026 msg_cnt SHALL wrap modulo 2^CNT_W without flagging.
REQ-027 msg_len=255 SHALL deliver exactly 255 body flits; counter SHALL never underflow.
REQ-028 Upstream stalls (noc_in_val=0) mid-body SHALL hold state and remaining unchanged.

Reset
REQ-029 On rst=1 at a clk edge: state=HDR_IN, remaining=0, hdr_data=0, msg_cnt=0; hence hdr_val=0, data_val=0, data_last=0, noc_in_rdy=1 the following cycle.
REQ-030 Reset mid-message SHALL drop the partial message silently; post-reset first flit accepted SHALL be treated as a header.
REQ-031 While rst=1, noc_in_rdy SHALL be 0 and no handshake SHALL be counted.

Verification
REQ-032 Header msg_len=0, hdr_rdy=1 -> hdr_val high exactly one cycle at N+1 with matching fields, data_val never high, msg_cnt=1.
REQ-033 Header msg_len=3 + 3 body flits (A,B,C), all ready -> data_data A,B,C on consecutive cycles, data_last only with C, msg_cnt=1, next flit parsed as header.
REQ-034 msg_len=2, hdr_rdy low 5 cycles -> hdr_data stable, noc_in_rdy=0 throughout, body flows only after hdr handshake.
REQ-035 msg_len=4, random data_rdy/noc_in_val gaps -> exactly 4 body transfers in order, data_last on 4th, no loss/duplication.
REQ-036 rst asserted after 2 of 5 body flits -> outputs at reset values next cycle, msg_cnt=0; next flit captured as header.
REQ-037 CNT_W=4, 17 zero-length messages -> msg_cnt reads 1 after wrap.
